// File: rtl/mp_add_seq.sv
// Multi-word add/subtract sequencer driving one external 32-bit adder.
// Processes one word per cycle, LSW first, then pulses done.
module mp_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [NWORDS*32-1:0]   a,
  input  logic [NWORDS*32-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [NWORDS*32-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [31:0]            cla_x,
  output logic [31:0]            cla_y,
  output logic                   cla_cin,
  input  logic [31:0]            cla_sum,
  input  logic                   cla_c32
);

  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [NWORDS-1:0][31:0] op_a;
  logic [NWORDS-1:0][31:0] op_b;
  logic [NWORDS-1:0][31:0] res;
  logic                    op_sub;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    last;

  assign last   = (idx == LAST);
  assign result = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Adder operands come only from registers, never from a/b/sub.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    cla_x    = '0;
    cla_y    = '0;
    cla_cin  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        cla_x   = op_a[idx];
        cla_y   = op_sub ? ~op_b[idx] : op_b[idx];
        cla_cin = carry;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      res       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_a   <= a;
        op_b   <= b;
        op_sub <= sub;
        idx    <= '0;
        carry  <= sub;
      end
      if (state == RUN) begin
        res[idx] <= cla_sum;
        carry    <= cla_c32;
        idx      <= idx + 1'b1;
        if (last) begin
          carry_out <= cla_c32;
          overflow  <= (op_a[NWORDS-1][31] == cla_y[31]) &&
                       (cla_sum[31] != op_a[NWORDS-1][31]);
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed corner cases plus random ops
// against a plain 128-bit arithmetic reference.
module tb_mp_add_seq;

  localparam int NW = 4;
  localparam int W  = NW * 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;
  logic [31:0]  cla_x, cla_y, cla_sum;
  logic         cla_cin, cla_c32;

  int n_checks = 0;
  int n_pass   = 0;

  mp_add_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .cla_x(cla_x), .cla_y(cla_y), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_c32(cla_c32)
  );

  // Stand-in for the external 32-bit adder.
  assign {cla_c32, cla_sum} = {1'b0, cla_x} + {1'b0, cla_y} + 33'(cla_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input bit s, output logic [W-1:0] r,
                                output bit c, output bit v);
    if (!s) begin
      {c, r} = {1'b0, x} + {1'b0, y};
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++)
      v[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input bit ts, input bit repulse, input string tag);
    logic [W-1:0] er;
    bit ec, ev, seen;
    int cyc;
    model(ta, tb, ts, er, ec, ev);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) begin
        start = 1'b0; a = ~ta; b = ~tb; sub = !ts;
        check({tag, " busy"}, busy, 1);
      end
      if (repulse && cyc == 2) begin
        start = 1'b1; a = rand_op(); b = rand_op();
      end
      if (repulse && cyc == 3) begin
        start = 1'b0;
        check({tag, " busy_repulse"}, busy, 1);
      end
      if (done) seen = 1;
    end
    check({tag, " latency"}, seen ? cyc : 0, NW + 1);
    check({tag, " result"}, result, er);
    check({tag, " carry"}, carry_out, ec);
    check({tag, " ovf"}, overflow, ev);
    start = 1'b1; a = rand_op(); b = rand_op();
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_1cyc"}, done, 0);
    check({tag, " idle"}, busy, 0);
    check({tag, " hold"}, result, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst carry", carry_out, 0);
    check("rst ovf", overflow, 0);
    check("rst cla_x", cla_x, 0);
    check("rst cla_y", cla_y, 0);
    check("rst cla_cin", cla_cin, 0);
    rst_n = 1'b1;

    run_op(1, ones, 0, 0, "wrap");
    run_op(128'hFFFF_FFFF, 1, 0, 0, "wordcarry");
    run_op(0, 1, 1, 0, "borrow");
    run_op({1'b0, {(W-1){1'b1}}}, 1, 0, 0, "posovf");
    run_op({1'b1, {(W-1){1'b0}}}, 1, 1, 0, "negovf");
    run_op(rand_op(), rand_op(), 0, 1, "repulse");
    check("cla_idle", {cla_x, cla_y, 31'b0, cla_cin}, 0);

    @(negedge clk);
    a = rand_op(); b = rand_op(); sub = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort flags", {carry_out, overflow}, 0);
    check("abort cla", {cla_x, cla_y, 31'b0, cla_cin}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort nodone", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
           128'h1111_1111_2222_2222_3333_3333_4444_4444, 1, 0, "postrst");

    for (int i = 0; i < 24; i++)
      run_op(rand_op(), rand_op(), $urandom_range(0, 1), i % 5 == 0,
             $sformatf("rnd%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
